// File: rtl/bus_xfer_master.sv
// Master-side transfer sequencer for the unit bus: reads a word from a source unit
// (or takes an immediate) and writes it to a destination unit, with a per-phase timeout.
module bus_xfer_master #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [3:0]        i_req_src_id,
    input  logic [3:0]        i_req_src_cmd,
    input  logic [3:0]        i_req_dst_id,
    input  logic [3:0]        i_req_dst_cmd,
    input  logic [DATA_W-1:0] i_req_imm,
    output logic [3:0]        o_read_id,
    output logic [3:0]        o_read_command,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_rd_valid,
    output logic [3:0]        o_write_id,
    output logic [3:0]        o_write_command,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_wr_valid,
    input  logic              i_wr_ack,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [7:0]        o_xfer_count
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    state_e            state_q;
    logic [3:0]        src_id_q, src_cmd_q, dst_id_q, dst_cmd_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q, error_q;
    logic [7:0]        count_q;
    logic              expired;

    // Last cycle of the wait window; a same-cycle valid/ack still takes priority.
    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            src_id_q  <= '0;
            src_cmd_q <= '0;
            dst_id_q  <= '0;
            dst_cmd_q <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_req_valid) begin
                        src_id_q  <= i_req_src_id;
                        src_cmd_q <= i_req_src_cmd;
                        dst_id_q  <= i_req_dst_id;
                        dst_cmd_q <= i_req_dst_cmd;
                        data_q    <= i_req_imm;
                        cnt_q     <= '0;
                        if (i_req_src_id != 4'd0) begin
                            state_q <= StRead;
                        end else if (i_req_dst_id != 4'd0) begin
                            state_q <= StWrite;
                        end else begin
                            done_q  <= 1'b1;
                            count_q <= count_q + 8'd1;
                        end
                    end
                end
                StRead: begin
                    if (i_rd_valid) begin
                        data_q <= i_rd_data;
                        cnt_q  <= '0;
                        if (dst_id_q != 4'd0) begin
                            state_q <= StWrite;
                        end else begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                            count_q <= count_q + 8'd1;
                        end
                    end else if (expired) begin
                        state_q <= StIdle;
                        error_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StWrite: begin
                    if (i_wr_ack) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                        count_q <= count_q + 8'd1;
                        cnt_q   <= '0;
                    end else if (expired) begin
                        state_q <= StIdle;
                        error_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_req_ready     = (state_q == StIdle);
    assign o_busy          = (state_q != StIdle);
    assign o_read_id       = (state_q == StRead)  ? src_id_q  : 4'd0;
    assign o_read_command  = (state_q == StRead)  ? src_cmd_q : 4'd0;
    assign o_write_id      = (state_q == StWrite) ? dst_id_q  : 4'd0;
    assign o_write_command = (state_q == StWrite) ? dst_cmd_q : 4'd0;
    assign o_wr_valid      = (state_q == StWrite);
    assign o_wr_data       = (state_q == StWrite) ? data_q : '0;
    assign o_done          = done_q;
    assign o_error         = error_q;
    assign o_xfer_count    = count_q;

endmodule

// File: tb/tb_bus_xfer_master.sv
// Directed bench for bus_xfer_master: read/write flow, immediate path, timeouts,
// back-to-back requests, counter wrap and asynchronous reset mid-transfer.
module tb_bus_xfer_master;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned TIMEOUT = 15;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_req_valid;
    logic              o_req_ready;
    logic [3:0]        i_req_src_id, i_req_src_cmd, i_req_dst_id, i_req_dst_cmd;
    logic [DATA_W-1:0] i_req_imm;
    logic [3:0]        o_read_id, o_read_command;
    logic [DATA_W-1:0] i_rd_data;
    logic              i_rd_valid;
    logic [3:0]        o_write_id, o_write_command;
    logic [DATA_W-1:0] o_wr_data;
    logic              o_wr_valid;
    logic              i_wr_ack;
    logic              o_busy, o_done, o_error;
    logic [7:0]        o_xfer_count;

    int n_tests = 0;
    int n_fail  = 0;

    bus_xfer_master #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_src_id   (i_req_src_id),
        .i_req_src_cmd  (i_req_src_cmd),
        .i_req_dst_id   (i_req_dst_id),
        .i_req_dst_cmd  (i_req_dst_cmd),
        .i_req_imm      (i_req_imm),
        .o_read_id      (o_read_id),
        .o_read_command (o_read_command),
        .i_rd_data      (i_rd_data),
        .i_rd_valid     (i_rd_valid),
        .o_write_id     (o_write_id),
        .o_write_command(o_write_command),
        .o_wr_data      (o_wr_data),
        .o_wr_valid     (o_wr_valid),
        .i_wr_ack       (i_wr_ack),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_error        (o_error),
        .o_xfer_count   (o_xfer_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs settle 1ns after the edge and inputs change there too.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] src, input logic [3:0] scmd,
                           input logic [3:0] dst, input logic [3:0] dcmd,
                           input logic [DATA_W-1:0] imm);
        i_req_valid   = 1'b1;
        i_req_src_id  = src;
        i_req_src_cmd = scmd;
        i_req_dst_id  = dst;
        i_req_dst_cmd = dcmd;
        i_req_imm     = imm;
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_req_valid = 1'b0;
        i_req_src_id = '0; i_req_src_cmd = '0; i_req_dst_id = '0; i_req_dst_cmd = '0;
        i_req_imm   = '0;
        i_rd_data   = '0;
        i_rd_valid  = 1'b0;
        i_wr_ack    = 1'b0;

        #12;
        check("rst_ready", o_req_ready, 1);
        check("rst_busy", o_busy, 0);
        check("rst_ids", {o_read_id, o_read_command, o_write_id, o_write_command}, 0);
        check("rst_wr", {o_wr_valid, o_wr_data}, 0);
        check("rst_pulses", {o_done, o_error}, 0);
        check("rst_count", o_xfer_count, 0);
        i_rst_n = 1'b1;
        step();

        // Read 0xBEEF from unit 3, write it to unit 5.
        set_req(4'd3, 4'd2, 4'd5, 4'd1, 16'h0000);
        check("t1_ready", o_req_ready, 1);
        step();
        i_req_valid = 1'b0;
        check("t1_rd_id", o_read_id, 3);
        check("t1_rd_cmd", o_read_command, 2);
        check("t1_wr_id_c1", o_write_id, 0);
        check("t1_busy", o_busy, 1);
        i_rd_valid = 1'b1;
        i_rd_data  = 16'hBEEF;
        step();
        i_rd_valid = 1'b0;
        i_rd_data  = 16'h0000;
        check("t1_wr_id", o_write_id, 5);
        check("t1_wr_cmd", o_write_command, 1);
        check("t1_wr_data", o_wr_data, 16'hBEEF);
        check("t1_wr_valid", o_wr_valid, 1);
        check("t1_rd_id_c2", o_read_id, 0);
        check("t1_done_early", o_done, 0);
        i_wr_ack = 1'b1;
        step();
        i_wr_ack = 1'b0;
        check("t1_done", o_done, 1);
        check("t1_error", o_error, 0);
        check("t1_count", o_xfer_count, 1);
        check("t1_ready_done", o_req_ready, 1);
        check("t1_wr_id_idle", o_write_id, 0);

        // Immediate 0x1234 to unit 7, issued on the done cycle.
        set_req(4'd0, 4'd0, 4'd7, 4'd3, 16'h1234);
        step();
        i_req_valid = 1'b0;
        check("t2_wr_id", o_write_id, 7);
        check("t2_wr_cmd", o_write_command, 3);
        check("t2_wr_data", o_wr_data, 16'h1234);
        check("t2_rd_id", o_read_id, 0);
        check("t2_done_clr", o_done, 0);
        i_wr_ack = 1'b1;
        step();
        i_wr_ack = 1'b0;
        check("t2_done", o_done, 1);
        check("t2_count", o_xfer_count, 2);

        // Read from unit 2 with no response: timeout after 15 cycles.
        set_req(4'd2, 4'd4, 4'd4, 4'd1, 16'h0000);
        for (int i = 1; i <= int'(TIMEOUT); i++) begin
            step();
            i_req_valid = 1'b0;
            check($sformatf("t3_rd_id_%0d", i), o_read_id, 2);
            check($sformatf("t3_wr_id_%0d", i), o_write_id, 0);
            check($sformatf("t3_err_%0d", i), o_error, 0);
        end
        step();
        check("t3_error", o_error, 1);
        check("t3_no_done", o_done, 0);
        check("t3_rd_id_idle", o_read_id, 0);
        check("t3_count", o_xfer_count, 2);
        step();
        check("t3_error_once", o_error, 0);

        // Write with ack arriving in the last timeout cycle.
        set_req(4'd0, 4'd0, 4'd6, 4'd2, 16'h5A5A);
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            step();
            i_req_valid = 1'b0;
            check($sformatf("t4_wr_valid_%0d", i), o_wr_valid, 1);
        end
        step();
        check("t4_wr_valid_last", o_wr_valid, 1);
        check("t4_wr_data_last", o_wr_data, 16'h5A5A);
        i_wr_ack = 1'b1;
        step();
        i_wr_ack = 1'b0;
        check("t4_done", o_done, 1);
        check("t4_no_error", o_error, 0);
        check("t4_count", o_xfer_count, 3);

        // Write timeout: no ack ever.
        set_req(4'd0, 4'd0, 4'd8, 4'd1, 16'h0F0F);
        for (int i = 1; i <= int'(TIMEOUT); i++) begin
            step();
            i_req_valid = 1'b0;
        end
        check("t5_wr_id_last", o_write_id, 8);
        step();
        check("t5_error", o_error, 1);
        check("t5_no_done", o_done, 0);
        check("t5_count", o_xfer_count, 3);

        // Null transfer: both ids zero completes straight from idle.
        set_req(4'd0, 4'd0, 4'd0, 4'd0, 16'h0000);
        step();
        i_req_valid = 1'b0;
        check("t6_done", o_done, 1);
        check("t6_busy", o_busy, 0);
        check("t6_ids", {o_read_id, o_write_id}, 0);
        check("t6_count", o_xfer_count, 4);

        // Back-to-back null transfers until the counter wraps.
        set_req(4'd0, 4'd0, 4'd0, 4'd0, 16'h0000);
        for (int i = 0; i < 251; i++) step();
        check("t7_count_255", o_xfer_count, 255);
        step();
        i_req_valid = 1'b0;
        check("t7_count_wrap", o_xfer_count, 0);
        check("t7_done", o_done, 1);
        step();
        check("t7_count_hold", o_xfer_count, 0);
        check("t7_done_clr", o_done, 0);

        // Asynchronous reset during a write.
        set_req(4'd0, 4'd0, 4'd9, 4'd5, 16'hAAAA);
        step();
        i_req_valid = 1'b0;
        check("t8_wr_id", o_write_id, 9);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("t8_rst_wr", {o_write_id, o_write_command, o_wr_valid, o_wr_data}, 0);
        check("t8_rst_ready", o_req_ready, 1);
        check("t8_rst_busy", o_busy, 0);
        check("t8_rst_count", o_xfer_count, 0);
        #3;
        i_rst_n = 1'b1;
        step();
        check("t8_no_pulse", {o_done, o_error}, 0);
        check("t8_idle", o_req_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
